data_memory_responder: RTL
==========================

Name: data_memory_responder

Overview:
- Memory-side responder for the multi-cycle CPU's data-memory port: a word-organised data RAM behind a valid/ready request and response handshake with a configurable access latency.
- The CPU's MEM-stage control issues one load or store at a time and stalls until the response handshake completes.
- The block also reports misaligned and out-of-range accesses, so the CPU control can trap instead of corrupting memory.

Parameters:
- DATA_LEN, 32, data word width in bits.
- ADDR_LEN, 32, byte-address width in bits.
- DEPTH_WORDS, 256, number of words in the RAM.
- LATENCY, 2, number of clock edges from request acceptance to resp_valid high. Legal range is 1 to 15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  the CPU presents a request.
- req_ready  out  1  the responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_LEN  byte address.
- req_wdata  in  DATA_LEN  store data.
- resp_valid  out  1  the response is available.
- resp_ready  in  1  the CPU accepts the response.
- resp_rdata  out  DATA_LEN  load data; 0 for stores and for errors.
- resp_err  out  1  the access was misaligned or out of range.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset:
  - Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
  - On rst: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0, latency counter = 0.
  - Every RAM word is cleared to 0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Acceptance happens on an edge where req_valid && req_ready.
  - At acceptance, capture req_write, req_addr and req_wdata; load counter = LATENCY-1; go to WAIT.
  - With no request, stay in IDLE.
- WAIT:
  - req_ready = 0.
  - While counter != 0, decrement the counter each edge.
  - On the edge where counter == 0, perform the access and go to RESP, with resp_valid = 1 from that edge.
  - Net timing: acceptance at edge N gives resp_valid high after edge N+LATENCY.
  - For LATENCY = 1, WAIT lasts exactly one cycle.
- Access, performed at the WAIT→RESP edge:
  - Word index = captured addr[ADDR_LEN-1:2].
  - Misaligned when captured addr[1:0] != 0. Out of range when the word index >= DEPTH_WORDS.
  - On either error: resp_err = 1, resp_rdata = 0, no RAM read or write.
  - Load: resp_rdata = RAM[index], resp_err = 0.
  - Store: RAM[index] = captured wdata, resp_rdata = 0, resp_err = 0. The write commits on this edge only.
- RESP:
  - resp_valid = 1. resp_rdata and resp_err stay stable until the handshake.
  - Handshake occurs on an edge with resp_valid && resp_ready. After it, the next state is IDLE, resp_valid = 0, resp_err = 0, and resp_rdata holds its last value.
  - req_ready becomes 1 only in the cycle after the handshake; there is no same-cycle accept.
- Input sampling:
  - Request inputs are sampled only at acceptance. Changes to req_* during WAIT or RESP are ignored.
  - A req_valid held high through RESP is accepted in the first IDLE cycle.
  - resp_ready is ignored outside RESP.
- Boundaries:
  - Address DEPTH_WORDS*4-4 is legal; address DEPTH_WORDS*4 gives an out-of-range error.
  - Upper address bits are not aliased.
  - Read-after-write to the same address in consecutive transactions returns the new data.
- Reset mid-operation: rst in WAIT or RESP aborts the transaction. A store not yet committed is dropped, and the RAM is cleared anyway.
- Counter: width is 4 bits and it never underflows.

Test Plan:
- Reset values: assert rst for 2 cycles, then release → req_ready = 1, busy = 0, resp_valid = 0, resp_rdata = 0. A load from 0x0 then returns 0x00000000.
- Store then load, LATENCY = 2:
  - Store 0xDEADBEEF to 0x10 accepted at edge N → resp_valid after edge N+2, resp_err = 0, resp_rdata = 0.
  - Load from 0x10 → resp_rdata = 0xDEADBEEF, after exactly 2 edges.
- Misaligned: store 0x12345678 to 0x13 → resp_err = 1. A subsequent load from 0x10 still returns 0xDEADBEEF.
- Out of range, DEPTH_WORDS = 256:
  - Load from 0x400 → resp_err = 1, resp_rdata = 0.
  - Load from 0x3FC → resp_err = 0.
- Backpressure: hold resp_ready = 0 for 3 cycles in RESP, toggling req_addr and req_wdata meanwhile → resp_valid, resp_rdata and resp_err stay stable. After resp_ready = 1, resp_valid drops and req_ready rises in the next cycle.
- Reset mid-WAIT: accept a store of 0xCAFEF00D to 0x20, assert rst in the first WAIT cycle → after reset, a load from 0x20 returns 0 and resp_valid never rose for the aborted store.

Source files
------------

// File: rtl/data_memory_responder.sv
// Data-memory responder for the multi-cycle CPU MEM stage: word-organised RAM
// behind a request/response handshake with a fixed access latency and error reporting.
module data_memory_responder #(
    parameter int DATA_LEN    = 32,
    parameter int ADDR_LEN    = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [DATA_LEN-1:0] req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    localparam int RAM_AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_count;
    logic                  r_write;
    logic [ADDR_LEN-1:0]   r_addr;
    logic [DATA_LEN-1:0]   r_wdata;
    logic [DATA_LEN-1:0]   r_rdata;
    logic                  r_err;
    logic [DATA_LEN-1:0]   r_mem [DEPTH_WORDS];

    logic [ADDR_LEN-3:0]   w_index;
    logic [RAM_AW-1:0]     w_ram_idx;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_err;
    logic                  w_access;

    // The access decode always works on the captured request, never on live inputs.
    assign w_index        = r_addr[ADDR_LEN-1:2];
    assign w_ram_idx      = w_index[RAM_AW-1:0];
    assign w_misaligned   = (r_addr[1:0] != 2'b00);
    assign w_out_of_range = (w_index >= (ADDR_LEN-2)'(DEPTH_WORDS));
    assign w_err          = w_misaligned || w_out_of_range;
    assign w_access       = (r_state == S_WAIT) && (r_count == 4'd0);

    // Handshakes: a request transfers on an edge with req_valid && req_ready, a
    // response on an edge with resp_valid && resp_ready; neither ready depends on valid.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_count == 4'd0) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_count <= 4'(LATENCY - 1);
                    end
                end
                S_WAIT: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        r_err   <= w_err;
                        r_rdata <= (w_err || r_write) ? '0 : r_mem[w_ram_idx];
                    end
                end
                S_RESP: begin
                    // rdata deliberately holds its last value after the handshake.
                    if (resp_ready) begin
                        r_err <= 1'b0;
                    end
                end
                default: begin
                    r_count <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_access && r_write && !w_err) begin
            r_mem[w_ram_idx] <= r_wdata;
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign dbg_state  = r_state;

endmodule
